// File: rtl/phy_pkg.sv
// Shared PHY lane/word constants, RX unstripe FSM state type and striping byte positions.
package phy_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } rx_state_e;

    // Byte slot (in LANE_W units from the LSB) of each lane byte within a word.
    localparam int unsigned BYTE_L0_K  = 3;
    localparam int unsigned BYTE_L1_K  = 2;
    localparam int unsigned BYTE_L0_K1 = 1;
    localparam int unsigned BYTE_L1_K1 = 0;

endpackage

// File: rtl/phy_rx_lane_fifo.sv
// Per-lane deskew FIFO: one byte push per cycle, two-byte pop, drop flagged on push into a full FIFO.
module phy_rx_lane_fifo
    import phy_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push,
    input  logic [LANE_W-1:0] din,
    input  logic              pop2,
    output logic [LANE_W-1:0] dout_hi,
    output logic [LANE_W-1:0] dout_lo,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              drop
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [LANE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push;

    assign full    = (count_q == DEPTH_C);
    // A pop in the same cycle frees room, so a full FIFO still accepts the byte.
    assign do_push = push & (~full | pop2);
    assign drop    = push & full & ~pop2;
    assign count   = count_q;
    assign dout_hi = mem_q[rd_ptr_q];
    assign dout_lo = mem_q[rd_ptr_q + PTR_W'(1)];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop2) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(2);
        end
        unique case ({do_push, pop2})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(2);
            2'b11:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/phy_rx_unstripe.sv
// Two-lane RX unstriper: deskews lane bytes and reassembles 32-bit words.
// Optional PHY_RX_WORD_CNT_EN adds a wrapping word_count output.
module phy_rx_unstripe
    import phy_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [LANE_W-1:0] data_in_0,
    input  logic              valid_in_0,
    input  logic [LANE_W-1:0] data_in_1,
    input  logic              valid_in_1,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              overflow_err
`ifdef PHY_RX_WORD_CNT_EN
    ,
    output logic [15:0]       word_count
`endif
);

    rx_state_e         state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic [LANE_W-1:0] hi_0, lo_0, hi_1, lo_1;
    logic [PTR_W:0]    count_0, count_1;
    logic              full_0, full_1;
    logic              drop_0, drop_1;
    logic              pop_ok;

    phy_rx_lane_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_lane0 (
        .clk_i(clk_4f), .rst_ni(reset), .push(valid_in_0), .din(data_in_0), .pop2(pop_ok),
        .dout_hi(hi_0), .dout_lo(lo_0), .count(count_0), .full(full_0), .drop(drop_0)
    );

    phy_rx_lane_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_lane1 (
        .clk_i(clk_4f), .rst_ni(reset), .push(valid_in_1), .din(data_in_1), .pop2(pop_ok),
        .dout_hi(hi_1), .dout_lo(lo_1), .count(count_1), .full(full_1), .drop(drop_1)
    );

    assign pop_ok = (count_0 >= (PTR_W + 1)'(2)) && (count_1 >= (PTR_W + 1)'(2));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q | drop_0 | drop_1;
        unique case (state_q)
            COLLECT: if (pop_ok)  state_d = EMIT;
            EMIT:    if (!pop_ok) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
        if (pop_ok) begin
            valid_d = 1'b1;
            data_d[BYTE_L0_K  * LANE_W +: LANE_W] = hi_0;
            data_d[BYTE_L1_K  * LANE_W +: LANE_W] = hi_1;
            data_d[BYTE_L0_K1 * LANE_W +: LANE_W] = lo_0;
            data_d[BYTE_L1_K1 * LANE_W +: LANE_W] = lo_1;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q <= COLLECT;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign overflow_err = ovf_q;

`ifdef PHY_RX_WORD_CNT_EN
    logic [15:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (valid_q) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign word_count = wcnt_q;
`endif

endmodule
